// File: rtl/gate_seq_pkg.sv
// Shared types and helpers for the gate vector sequencer self-test.
// Latency: none; this file holds only declarations and a pure function.
// Backpressure: not applicable.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit positions on the gates-block output bus.
  localparam int IDX_NY  = 6;
  localparam int IDX_AY  = 5;
  localparam int IDX_OY  = 4;
  localparam int IDX_NAY = 3;
  localparam int IDX_NOY = 2;
  localparam int IDX_XY  = 1;
  localparam int IDX_XNY = 0;

  localparam int NUM_VECTORS = 4;

  // Expected gates-block outputs for a given A/B input pair.
  function automatic logic [6:0] golden_gates(input logic a, input logic b);
    logic [6:0] g;
    g          = '0;
    g[IDX_NY]  = ~a;
    g[IDX_AY]  = a & b;
    g[IDX_OY]  = a | b;
    g[IDX_NAY] = ~(a & b);
    g[IDX_NOY] = ~(a | b);
    g[IDX_XY]  = a ^ b;
    g[IDX_XNY] = ~(a ^ b);
    return g;
  endfunction

endpackage

// File: rtl/gate_vector_sequencer_golden.sv
// Golden truth table of the two-input basic-gates block.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the inputs continuously.
module gate_golden_model
  import gate_seq_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [6:0] expected
);

  assign expected = golden_gates(a, b);

endmodule

// File: rtl/gate_vector_sequencer.sv
// Built-in self-test sequencer: walks A/B through 00,01,10,11 and checks the gates block.
// Latency: a pass takes 4*HOLD_CYCLES cycles from the start edge to done.
// Backpressure: none; start is ignored while busy. Optional looping via GATE_SEQ_LOOP_EN.
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef GATE_SEQ_LOOP_EN
  input  logic             loop_mode,
`endif
  input  logic [6:0]       gate_out,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t           state, state_nxt;
  logic [1:0]       vec_idx, vec_nxt;
  logic [HC_W-1:0]  hold_cnt, hold_nxt;
  logic [ERR_W-1:0] err_q, err_nxt, err_sat;
  logic [3:0]       fv_q, fv_nxt;
  logic [6:0]       expected;
  logic [6:0]       mismatch;
  logic [2:0]       miss_cnt;
  logic [ERR_W+2:0] err_sum;
  logic             sample_hit;
  logic             last_vec;
  logic             loop_on;

`ifdef GATE_SEQ_LOOP_EN
  assign loop_on = loop_mode;
`else
  assign loop_on = 1'b0;
`endif

  // A/B come straight from the vector index flops, so they are glitch-free registers.
  assign a = vec_idx[1];
  assign b = vec_idx[0];

  gate_golden_model u_golden (
    .a        (a),
    .b        (b),
    .expected (expected)
  );

  assign mismatch   = gate_out ^ expected;
  assign sample_hit = (hold_cnt == HC_W'(HOLD_CYCLES - 1));
  assign last_vec   = (vec_idx == 2'(NUM_VECTORS - 1));

  // Count mismatched bits and add them to the running total without wrapping.
  always_comb begin
    miss_cnt = '0;
    for (int i = 0; i < 7; i++) begin
      miss_cnt = miss_cnt + {2'b00, mismatch[i]};
    end
    err_sum = {3'b000, err_q} + {{ERR_W{1'b0}}, miss_cnt};
    if (err_sum > {3'b000, {ERR_W{1'b1}}}) begin
      err_sat = '1;
    end else begin
      err_sat = err_sum[ERR_W-1:0];
    end
  end

  // Next-state and datapath update: clear on start, accumulate on each sample cycle.
  always_comb begin
    state_nxt = state;
    vec_nxt   = vec_idx;
    hold_nxt  = hold_cnt;
    err_nxt   = err_q;
    fv_nxt    = fv_q;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = DRIVE;
          vec_nxt   = '0;
          hold_nxt  = '0;
          err_nxt   = '0;
          fv_nxt    = '0;
        end
      end
      DRIVE: begin
        if (sample_hit) begin
          hold_nxt = '0;
          err_nxt  = err_sat;
          if (mismatch != '0) begin
            fv_nxt[vec_idx] = 1'b1;
          end
          if (!last_vec) begin
            vec_nxt = vec_idx + 2'd1;
          end else if (loop_on) begin
            vec_nxt = '0;
          end else begin
            state_nxt = DONE;
          end
        end else begin
          hold_nxt = hold_cnt + HC_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      vec_idx  <= '0;
      hold_cnt <= '0;
      err_q    <= '0;
      fv_q     <= '0;
    end else begin
      state    <= state_nxt;
      vec_idx  <= vec_nxt;
      hold_cnt <= hold_nxt;
      err_q    <= err_nxt;
      fv_q     <= fv_nxt;
    end
  end

  assign busy      = (state == DRIVE);
  assign done      = (state == DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;
  assign fail_vec  = fv_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Bench for gate_vector_sequencer: two instances (hold 4 / 5-bit count, hold 1 / 4-bit count).
// Latency: results are checked when done rises, against a queue filled by the stimulus.
// Backpressure: not applicable; a faulty gates block is modelled with bit masks.
module tb_gate_vector_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start0, start1, loop_mode;
  logic       a0, b0, busy0, done0, pass0;
  logic       a1, b1, busy1, done1, pass1;
  logic [4:0] err0;
  logic [3:0] err1;
  logic [3:0] fv0, fv1;
  logic [6:0] go0, go1;
  logic [6:0] inv_mask, clr_mask, set_mask;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int sc0   = 0;
  int sc1   = 0;

  typedef struct {
    int pass;
    int err;
    int fv;
    int lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference gates, bus order NY AY OY NAY NOY XY XNY.
  function automatic logic [6:0] ref_gates(input logic a, input logic b);
    return {~a, a & b, a | b, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
  endfunction

  assign go0 = ((ref_gates(a0, b0) ^ inv_mask) & ~clr_mask) | set_mask;
  assign go1 = ((ref_gates(a1, b1) ^ inv_mask) & ~clr_mask) | set_mask;

  always @(posedge clk) cyc <= cyc + 1;

  gate_vector_sequencer #(.HOLD_CYCLES(4), .ERR_W(5)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .start     (start0),
`ifdef GATE_SEQ_LOOP_EN
    .loop_mode (loop_mode),
`endif
    .gate_out  (go0),
    .a         (a0),
    .b         (b0),
    .busy      (busy0),
    .done      (done0),
    .pass      (pass0),
    .err_count (err0),
    .fail_vec  (fv0)
  );

  gate_vector_sequencer #(.HOLD_CYCLES(1), .ERR_W(4)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
`ifdef GATE_SEQ_LOOP_EN
    .loop_mode (loop_mode),
`endif
    .gate_out  (go1),
    .a         (a1),
    .b         (b1),
    .busy      (busy1),
    .done      (done1),
    .pass      (pass1),
    .err_count (err1),
    .fail_vec  (fv1)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset0(input string tag);
    check({tag, "_a"}, a0, 0);
    check({tag, "_b"}, b0, 0);
    check({tag, "_busy"}, busy0, 0);
    check({tag, "_done"}, done0, 0);
    check({tag, "_pass"}, pass0, 0);
    check({tag, "_err"}, err0, 0);
    check({tag, "_fv"}, fv0, 0);
  endtask

  // Start pulse; upd records the start edge as the reference for elapsed cycles.
  task automatic pulse(input int which, input bit upd);
    @(negedge clk);
    if (which == 0) start0 = 1'b1;
    else start1 = 1'b1;
    @(posedge clk);
    if (upd) begin
      if (which == 0) sc0 = cyc + 1;
      else sc1 = cyc + 1;
    end
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_el0(input int e);
    do @(negedge clk); while (cyc - sc0 < e);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q0.size() + q1.size()) > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if ((q0.size() + q1.size()) != 0) begin
      check("drain_timeout", q0.size() + q1.size(), 0);
      q0.delete();
      q1.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic expect0(input int p, input int e, input int f, input int l);
    exp_t x;
    x.pass = p; x.err = e; x.fv = f; x.lat = l;
    q0.push_back(x);
  endtask

  task automatic expect1(input int p, input int e, input int f, input int l);
    exp_t x;
    x.pass = p; x.err = e; x.fv = f; x.lat = l;
    q1.push_back(x);
  endtask

  // Monitor for dut0: A/B trace while busy, and scoreboard pop on each done rise.
  initial begin
    logic dp;
    exp_t e;
    dp = 1'b0;
    forever begin
      @(negedge clk);
      if (busy0) check("ab_trace0", {a0, b0}, ((cyc - sc0) / 4) % 4);
      if (done0 && !dp) begin
        if (q0.size() == 0) begin
          check("unexpected_done0", 1, 0);
        end else begin
          e = q0.pop_front();
          check("pass0", pass0, e.pass);
          check("err_count0", err0, e.err);
          check("fail_vec0", fv0, e.fv);
          check("done_latency0", cyc - sc0, e.lat);
          check("done_ab0", {a0, b0}, 3);
          check("done_busy0", busy0, 0);
        end
      end
      dp = done0;
    end
  end

  // Monitor for dut1.
  initial begin
    logic dp;
    exp_t e;
    dp = 1'b0;
    forever begin
      @(negedge clk);
      if (busy1) check("ab_trace1", {a1, b1}, (cyc - sc1) % 4);
      if (done1 && !dp) begin
        if (q1.size() == 0) begin
          check("unexpected_done1", 1, 0);
        end else begin
          e = q1.pop_front();
          check("pass1", pass1, e.pass);
          check("err_count1", err1, e.err);
          check("fail_vec1", fv1, e.fv);
          check("done_latency1", cyc - sc1, e.lat);
        end
      end
      dp = done1;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; loop_mode = 1'b0;
    inv_mask = '0; clr_mask = '0; set_mask = '0;
    repeat (3) @(negedge clk);
    chk_reset0("reset0");
    check("reset1_busy", busy1, 0);
    check("reset1_done", done1, 0);
    check("reset1_err", err1, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Healthy gates block.
    expect0(1, 0, 0, 16);
    pulse(0, 1);
    drain();

    // XY stuck at 0: vectors 01 and 10 each lose one bit.
    clr_mask = 7'b0000010;
    expect0(0, 2, 4'b0110, 16);
    pulse(0, 1);
    drain();

    // Restart from DONE with a healthy block: counters cleared right after the start edge.
    clr_mask = '0;
    expect0(1, 0, 0, 16);
    pulse(0, 1);
    check("restart_err_clr", err0, 0);
    check("restart_fv_clr", fv0, 0);
    check("restart_busy", busy0, 1);
    drain();

    // NY stuck at 1, with a stray start during DRIVE that must be ignored.
    set_mask = 7'b1000000;
    expect0(0, 2, 4'b1100, 16);
    pulse(0, 1);
    wait_el0(6);
    pulse(0, 0);
    drain();
    set_mask = '0;

    // All outputs inverted: 28 mismatches fit in 5 bits.
    inv_mask = 7'b1111111;
    expect0(0, 28, 4'b1111, 16);
    pulse(0, 1);
    drain();

    // AY inverted only: one mismatch per vector.
    inv_mask = 7'b0100000;
    expect0(0, 4, 4'b1111, 16);
    pulse(0, 1);
    drain();

    // Reset in the middle of a pass, then a clean pass.
    inv_mask = '0;
    pulse(0, 1);
    wait_el0(9);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset0("midrst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_no_done", done0, 0);
    expect0(1, 0, 0, 16);
    pulse(0, 1);
    drain();

    // Hold of one cycle: healthy, then XY fault, then saturation of a 4-bit count.
    expect1(1, 0, 0, 4);
    pulse(1, 1);
    drain();
    clr_mask = 7'b0000010;
    expect1(0, 2, 4'b0110, 4);
    pulse(1, 1);
    drain();
    clr_mask = '0;
    inv_mask = 7'b1111111;
    expect1(0, 15, 4'b1111, 4);
    pulse(1, 1);
    drain();
    inv_mask = '0;

`ifdef GATE_SEQ_LOOP_EN
    // Looping with the XY fault: two more errors per pass, done held low until loop_mode drops.
    loop_mode = 1'b1;
    clr_mask  = 7'b0000010;
    pulse(0, 1);
    wait_el0(16);
    check("loop_err_pass1", err0, 2);
    check("loop_done_low", done0, 0);
    check("loop_busy", busy0, 1);
    wait_el0(20);
    loop_mode = 1'b0;
    expect0(0, 4, 4'b0110, 32);
    drain();
    clr_mask = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
